// File: rtl/lz_pkg.sv
// Shared widths, FSM state encoding and helpers for the LZ77 back-reference expander.
package lz_pkg;

    localparam int DATA_W   = 4;
    localparam int SYM_W    = 5;
    localparam int EXT_W    = 6;
    localparam int ADDR_W   = 9;
    localparam int LEN_W    = 7;
    localparam int LEN_BASE = 3;

    localparam logic [SYM_W-1:0] EOB_CODE = 5'h1F;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIST     = 2'd1,
        PREFETCH = 2'd2,
        COPY     = 2'd3
    } state_t;

    function automatic logic is_eob(input logic [SYM_W-1:0] sym);
        return sym == EOB_CODE;
    endfunction

endpackage

// File: rtl/lz_copy_engine.sv
// Copy-side bookkeeping: read pointer, remaining length and look-ahead history address.
module lz_copy_engine
    import lz_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_len,
    input  logic [LEN_W-1:0]  len_in,
    input  logic              load_rp,
    input  logic [ADDR_W-1:0] rp_in,
    input  logic              step,
    output logic [ADDR_W-1:0] read_addr,
    output logic              done
);

    logic [ADDR_W-1:0] rp;
    logic [LEN_W-1:0]  len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp  <= '0;
            len <= '0;
        end else begin
            if (load_rp) begin
                rp <= rp_in;
            end else if (step) begin
                rp <= rp + ADDR_W'(1);
            end
            if (load_len) begin
                len <= len_in;
            end else if (step) begin
                len <= len - LEN_W'(1);
            end
        end
    end

    // Presenting rp+1 on a beat keeps the registered-address buffer one step ahead,
    // which also makes overlapping copies see the nibble written in the same cycle.
    assign read_addr = step ? rp + ADDR_W'(1) : rp;
    assign done      = step & (len == LEN_W'(1));

endmodule

// File: rtl/lz_extract_engine.sv
// LZ77 expander: literals pass through, length/distance pairs replay history.
// Optional end-of-block symbol and eob pulse output enabled by defining LZ_EOB_EN.
module lz_extract_engine
    import lz_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              data_in_vld,
    input  logic [SYM_W-1:0]  data_in,
    input  logic [EXT_W-1:0]  ext_bits,
    output logic              data_in_rdy,
    input  logic              data_out_rdy,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_vld,
    output logic [ADDR_W-1:0] buff_read_addr,
    output logic [ADDR_W-1:0] buff_write_addr,
    input  logic [DATA_W-1:0] buff_data_in
`ifdef LZ_EOB_EN
    ,
    output logic              eob
`endif
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wp;
    logic              sym_acc, out_hs, eob_sym, is_len;
    logic              len_load, rp_load, step, copy_done;
    logic [LEN_W-1:0]  len_val;
    logic [ADDR_W-1:0] dist_val, rp_val;

`ifdef LZ_EOB_EN
    assign eob_sym = is_eob(data_in);
`else
    assign eob_sym = 1'b0;
`endif

    assign sym_acc  = data_in_vld & data_in_rdy;
    assign out_hs   = data_out_vld & data_out_rdy;
    assign is_len   = data_in[SYM_W-1] & ~eob_sym;
    assign len_load = (state == IDLE) & sym_acc & is_len;
    assign rp_load  = (state == DIST) & sym_acc;
    assign step     = (state == COPY) & out_hs;

    assign len_val  = LEN_W'(LEN_BASE) + LEN_W'(data_in[DATA_W-1:0]) + LEN_W'(ext_bits);
    // A distance of 512 wraps to 0 here, so the copy starts at wp (oldest entry).
    assign dist_val = {data_in[2:0], ext_bits} + ADDR_W'(1);
    assign rp_val   = wp - dist_val;

    lz_copy_engine u_copy (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_len  (len_load),
        .len_in    (len_val),
        .load_rp   (rp_load),
        .rp_in     (rp_val),
        .step      (step),
        .read_addr (buff_read_addr),
        .done      (copy_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (len_load)  state_nxt = DIST;
            DIST:     if (sym_acc)   state_nxt = PREFETCH;
            PREFETCH: if (en)        state_nxt = COPY;
            COPY:     if (copy_done) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted.
    always_comb begin
        data_in_rdy  = 1'b0;
        data_out_vld = 1'b0;
        data_out     = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    data_in_rdy = en & data_out_rdy;
                    if (en & data_in_vld & ~data_in[SYM_W-1]) begin
                        data_out_vld = 1'b1;
                        data_out     = data_in[DATA_W-1:0];
                    end
                end
                DIST: data_in_rdy = en;
                COPY: begin
                    data_out_vld = en;
                    data_out     = en ? buff_data_in : '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
        end else if (out_hs) begin
            wp <= wp + ADDR_W'(1);
        end
    end

    assign buff_write_addr = wp;

`ifdef LZ_EOB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eob <= 1'b0;
        end else begin
            eob <= (state == IDLE) & sym_acc & eob_sym;
        end
    end
`endif

endmodule

// File: tb/tb_lz_extract_engine.sv
// Directed and randomized bench for lz_extract_engine with a history-level reference model.
module tb_lz_extract_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       data_in_vld = 1'b0;
    logic [4:0] data_in = '0;
    logic [5:0] ext_bits = '0;
    logic       data_in_rdy;
    logic       data_out_rdy = 1'b0;
    logic [3:0] data_out;
    logic       data_out_vld;
    logic [8:0] buff_read_addr;
    logic [8:0] buff_write_addr;
    logic [3:0] buff_data_in;
`ifdef LZ_EOB_EN
    logic       eob;
`endif

    always #5 clk = ~clk;

    lz_extract_engine dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en              (en),
        .data_in_vld     (data_in_vld),
        .data_in         (data_in),
        .ext_bits        (ext_bits),
        .data_in_rdy     (data_in_rdy),
        .data_out_rdy    (data_out_rdy),
        .data_out        (data_out),
        .data_out_vld    (data_out_vld),
        .buff_read_addr  (buff_read_addr),
        .buff_write_addr (buff_write_addr),
        .buff_data_in    (buff_data_in)
`ifdef LZ_EOB_EN
        ,
        .eob             (eob)
`endif
    );

    // External history buffer: written on each output handshake, registered read address.
    logic [3:0] mem [512];
    logic [8:0] raddr_q;
    always @(posedge clk) begin
        if (data_out_vld && data_out_rdy) mem[buff_write_addr] <= data_out;
        raddr_q <= buff_read_addr;
    end
    assign buff_data_in = mem[raddr_q];

    // Reference model: the output history as an LZ77 window.
    logic [3:0] ref_hist [512];
    logic [3:0] exp_q [$];
    int         wp_ref = 0;
    int         exp_wa = 0;
    bit         want_dist = 0;
    int         pend_len = 0;

    int checks = 0;
    int failures = 0;

    bit   rdy_rand = 0;
    bit   en_pat [$];
    bit   rdy_pat [$];
    bit   prev_hold = 0;
    logic [8:0] prev_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_accept(input logic [4:0] s, input logic [5:0] e);
        int d;
        logic [3:0] v;
        if (want_dist) begin
            d = {s[2:0], e} + 1;
            for (int i = 0; i < pend_len; i++) begin
                v = ref_hist[(wp_ref - d + 512) % 512];
                ref_hist[wp_ref] = v;
                exp_q.push_back(v);
                wp_ref = (wp_ref + 1) % 512;
            end
            want_dist = 0;
`ifdef LZ_EOB_EN
        end else if (s == 5'h1F) begin
            want_dist = 0;
`endif
        end else if (s[4]) begin
            pend_len = 3 + int'(s[3:0]) + int'(e);
            want_dist = 1;
        end else begin
            ref_hist[wp_ref] = s[3:0];
            exp_q.push_back(s[3:0]);
            wp_ref = (wp_ref + 1) % 512;
        end
    endtask

    task automatic cycle(input bit v, input logic [4:0] s, input logic [5:0] e, output bit acc);
        logic [3:0] expd;
        @(negedge clk);
        data_in_vld = v;
        data_in = s;
        ext_bits = e;
        en = (en_pat.size() > 0) ? en_pat.pop_front() : 1'b1;
        if (rdy_pat.size() > 0) data_out_rdy = rdy_pat.pop_front();
        else data_out_rdy = rdy_rand ? ($urandom_range(99) < 70) : 1'b1;
        #1;
        acc = data_in_vld && data_in_rdy;
        if (acc) model_accept(s, e);
        if (!en) begin
            check("rdy_en_low", 32'(data_in_rdy), 0);
            check("vld_en_low", 32'(data_out_vld), 0);
        end
        if (!data_out_vld) check("dout_zero_idle", 32'(data_out), 0);
        if (prev_hold && !(data_out_vld && data_out_rdy))
            check("read_addr_hold", 32'(buff_read_addr), 32'(prev_addr));
        if (data_out_vld && data_out_rdy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(data_out_vld), 0);
            end else begin
                expd = exp_q.pop_front();
                check("data_out", 32'(data_out), 32'(expd));
                check("write_addr", 32'(buff_write_addr), 32'(exp_wa));
                exp_wa = (exp_wa + 1) % 512;
            end
        end
        prev_hold = !en || (data_out_vld && !data_out_rdy);
        prev_addr = buff_read_addr;
    endtask

    task automatic send(input logic [4:0] s, input logic [5:0] e);
        bit acc;
        int n;
        n = 0;
        acc = 0;
        while (!acc && n < 400) begin
            cycle(1'b1, s, e, acc);
            n++;
        end
        if (!acc) check("send_timeout", 32'(acc), 1);
    endtask

    task automatic drain(output int ncyc);
        bit acc;
        ncyc = 0;
        while (exp_q.size() > 0 && ncyc < 3000) begin
            cycle(1'b0, 5'd0, 6'd0, acc);
            ncyc++;
            if (data_out_vld) check("rdy_during_copy", 32'(data_in_rdy), 0);
        end
        check("drain_timeout", 32'(exp_q.size()), 0);
    endtask

    task automatic check_wp(input string tag, input int expv);
        @(posedge clk);
        #1;
        check(tag, 32'(buff_write_addr), 32'(expv));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b1;
        data_out_rdy = 1'b1;
        data_in_vld = 1'b1;
        data_in = 5'h07;
        #1;
        check("rst_rdy", 32'(data_in_rdy), 0);
        check("rst_vld", 32'(data_out_vld), 0);
        check("rst_dout", 32'(data_out), 0);
        @(negedge clk);
        #1;
        check("rst_waddr", 32'(buff_write_addr), 0);
        check("rst_raddr", 32'(buff_read_addr), 0);
        exp_q.delete();
        en_pat.delete();
        rdy_pat.delete();
        wp_ref = 0;
        exp_wa = 0;
        want_dist = 0;
        prev_hold = 0;
        @(negedge clk);
        rst_n = 1'b1;
        data_in_vld = 1'b0;
    endtask

    initial begin
        int n;
        bit acc;
        for (int i = 0; i < 512; i++) ref_hist[i] = '0;

        do_reset();

        // Plain literals, same-cycle output.
        send(5'h01, 6'd0);
        send(5'h02, 6'd0);
        send(5'h03, 6'd0);
        check_wp("wp_after_lits", 3);

        // Non-overlapping copy, dist 3 len 3.
        send(5'h0A, 6'd0);
        send(5'h0B, 6'd0);
        send(5'h0C, 6'd0);
        send(5'h10, 6'd0);
        send(5'h00, 6'd2);
        drain(n);
        check("copy3_cycles", 32'(n), 4);
        check_wp("wp_after_copy3", 9);

        // Overlapping copy, dist 1 len 7.
        send(5'h05, 6'd0);
        send(5'h10, 6'd4);
        send(5'h00, 6'd0);
        drain(n);
        check("rle_cycles", 32'(n), 8);
        check_wp("wp_after_rle", 17);

        // Downstream stalls during a len 4 copy.
        send(5'h06, 6'd0);
        send(5'h07, 6'd0);
        send(5'h08, 6'd0);
        send(5'h09, 6'd0);
        send(5'h11, 6'd0);
        send(5'h00, 6'd3);
        rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        drain(n);
        check("stall_cycles", 32'(n), 7);
        check_wp("wp_after_stall", 25);

        // Enable dropped for 3 cycles mid-copy.
        send(5'h13, 6'd0);
        send(5'h00, 6'd3);
        en_pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        drain(n);
        check("en_drop_cycles", 32'(n), 10);
        check_wp("wp_after_en_drop", 31);

        // Window wrap and a full 512 distance.
        do_reset();
        for (int i = 0; i < 520; i++) send({1'b0, 4'($urandom_range(15))}, 6'($urandom_range(63)));
        check_wp("wp_wrap", 8);
        send(5'h10, 6'd0);
        send(5'h07, 6'd63);
        drain(n);
        check_wp("wp_after_d512", 11);

        // Symbol 0x1F with extra bits.
        send(5'h1F, 6'd1);
        send(5'h00, 6'd6);
        drain(n);
        check_wp("wp_after_1f", 32'(wp_ref));

        // Reset in the middle of a copy abandons it.
        send(5'h1F, 6'd2);
        send(5'h00, 6'd4);
        for (int i = 0; i < 5; i++) cycle(1'b0, 5'd0, 6'd0, acc);
        do_reset();
        send(5'h0E, 6'd0);
        check_wp("wp_after_midreset", 1);

        // Randomized traffic with backpressure and enable drops.
        rdy_rand = 1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(9) == 0) begin
                en_pat.push_back(1'b0);
                en_pat.push_back(1'b0);
            end
            if ($urandom_range(99) < 60) begin
                send({1'b0, 4'($urandom_range(15))}, 6'($urandom_range(63)));
            end else begin
                send({1'b1, 4'($urandom_range(15))}, 6'($urandom_range(63)));
                send(5'($urandom_range(31)), 6'($urandom_range(63)));
            end
        end
        drain(n);
        check_wp("wp_after_random", wp_ref);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
